// File: rtl/bram_rd_pkg.sv
// Shared constants and FSM encoding for the BRAM stream reader.
package bram_rd_pkg;

    localparam int DLEN_DEF = 32;
    localparam int HLEN_DEF = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bram_rd_fifo2.sv
// Two-entry show-ahead buffer; head word always sits in ent0_q so the output is a plain register.
module bram_rd_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= din_i;
                    else               ent1_q <= din_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind the survivor.
                    if (cnt_q == 2'd2) begin
                        ent0_q <= ent1_q;
                        ent1_q <= din_i;
                    end else begin
                        ent0_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_o  = ent0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a strided burst of words out of an external registered-read BRAM onto a valid/ready port.
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int DLEN = DLEN_DEF,
    parameter int HLEN = HLEN_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [HLEN-1:0] base_addr,
    input  logic [HLEN-1:0] stride,
    input  logic [HLEN:0]   len,
    output logic [HLEN-1:0] raddr,
    input  logic [DLEN-1:0] rdata,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DLEN-1:0] m_data,
    output logic            m_last,
    output logic            busy,
    output logic            done
);

    state_e          state_q;
    logic [HLEN-1:0] raddr_q, stride_q;
    logic [HLEN:0]   remain_q;
    logic            infl_q, infl_last_q;
    logic            busy_q, done_q;

    logic [1:0]      occ;
    logic [2:0]      credit;
    logic            beat, issue, issue_last;
    logic [DLEN:0]   fifo_dout;

    // raddr_q always holds the next address; a cycle "issues" it by setting infl_q,
    // so the BRAM word registered at that edge is pushed on the following edge.
    always_comb begin
        beat       = m_valid & m_ready;
        credit     = {1'b0, occ} + {2'b00, infl_q} - {2'b00, beat};
        issue      = (state_q == S_READ) && (credit < 3'd2);
        issue_last = issue && (remain_q == (HLEN+1)'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            raddr_q     <= '0;
            stride_q    <= '0;
            remain_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            infl_q      <= issue;
            infl_last_q <= issue_last;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            raddr_q  <= base_addr;
                            stride_q <= stride;
                            remain_q <= len;
                            busy_q   <= 1'b1;
                            state_q  <= S_READ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        raddr_q  <= raddr_q + stride_q;
                        remain_q <= remain_q - (HLEN+1)'(1);
                        if (issue_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (beat && m_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    bram_rd_fifo2 #(.W(DLEN + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (infl_q),
        .din_i   ({infl_last_q, rdata}),
        .pop_i   (beat),
        .dout_o  (fifo_dout),
        .valid_o (m_valid),
        .count_o (occ)
    );

    assign raddr  = raddr_q;
    assign m_data = fifo_dout[DLEN-1:0];
    assign m_last = fifo_dout[DLEN];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM and an expected-word scoreboard.
module tb_bram_stream_reader;

    localparam int DLEN = 32;
    localparam int HLEN = 9;
    localparam int DEPTH = 1 << HLEN;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [HLEN-1:0] base_addr, stride;
    logic [HLEN:0]   len;
    logic [HLEN-1:0] raddr;
    logic [DLEN-1:0] rdata;
    logic            m_valid, m_ready, m_last, busy, done;
    logic [DLEN-1:0] m_data;

    logic [DLEN-1:0] mem [0:DEPTH-1];
    logic [DLEN:0]   exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int beats = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    logic            stall_prev = 1'b0;
    logic [DLEN-1:0] stall_data = '0;
    logic            stall_last = 1'b0;

    bram_stream_reader #(.DLEN(DLEN), .HLEN(HLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .len       (len),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: whatever handshake is visible now completes at the next rising edge.
    task automatic mon();
        logic [DLEN:0] e;
        if (stall_prev) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, stall_data);
            chk("stall_last", m_last, stall_last);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {m_last, m_data}, '1);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_data, e[DLEN-1:0]);
                chk("beat_last", m_last, e[DLEN]);
            end
            if (beats == 0) first_beat_cyc = cyc_n;
            last_beat_cyc = cyc_n;
            beats++;
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
        stall_last = m_last;
    endtask

    task automatic clk_cycle();
        mon();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic kick(input int b, input int s, input int n, input logic expect_words);
        logic [DLEN:0] w;
        start     = 1'b1;
        base_addr = HLEN'(b);
        stride    = HLEN'(s);
        len       = (HLEN+1)'(n);
        beats     = 0;
        if (expect_words) begin
            for (int i = 0; i < n; i++) begin
                w = {(i == n - 1), mem[(b + i * s) % DEPTH]};
                exp_q.push_back(w);
            end
        end
    endtask

    // Runs to the done pulse; ready_pat bit (cycle % 4) drives m_ready each cycle.
    task automatic wait_done(input string tag, input logic [3:0] ready_pat, input int budget);
        logic pre;
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            m_ready = ready_pat[cyc_n % 4];
            pre = m_valid && m_ready && m_last;
            clk_cycle();
            if (pre) begin
                chk({tag, "_done_after_last"}, done, 1'b1);
                chk({tag, "_idle_after_last"}, busy, 1'b0);
                got = 1'b1;
            end
        end
        if (!got) chk({tag, "_timeout"}, 1'b0, 1'b1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DLEN'(i);
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        stride = '0;
        len = '0;
        m_ready = 1'b1;
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Linear burst at full rate: first word in cycle 3, one beat per cycle.
        kick(0, 1, 8, 1'b1);
        clk_cycle();
        start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_raddr_c1", raddr, 0);
        chk("t1_nvalid_c1", m_valid, 1'b0);
        clk_cycle();
        chk("t1_nvalid_c2", m_valid, 1'b0);
        clk_cycle();
        chk("t1_valid_c3", m_valid, 1'b1);
        chk("t1_data_c3", m_data, 0);
        wait_done("t1", 4'b1111, 40);
        chk("t1_beats", beats, 8);
        chk("t1_span", last_beat_cyc - first_beat_cyc, 7);

        // Back-to-back start on the done cycle, address wrap past the top of the BRAM.
        kick(510, 3, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            clk_cycle();
            start = 1'b0;
            chk("t2_raddr", raddr, (510 + i * 3) % DEPTH);
        end
        wait_done("t2", 4'b1111, 40);
        chk("t2_beats", beats, 4);

        // Back-pressure: ready follows 1,0,0,1.
        clk_cycle();
        kick(100, 5, 8, 1'b1);
        clk_cycle();
        start = 1'b0;
        wait_done("t3", 4'b1001, 120);
        chk("t3_beats", beats, 8);
        m_ready = 1'b1;

        // Zero-length start, then start ignored while busy.
        clk_cycle();
        kick(7, 1, 0, 1'b1);
        clk_cycle();
        start = 1'b0;
        chk("t4_len0_done", done, 1'b1);
        chk("t4_len0_busy", busy, 1'b0);
        chk("t4_len0_valid", m_valid, 1'b0);
        clk_cycle();
        chk("t4_len0_done_clr", done, 1'b0);
        chk("t4_len0_valid2", m_valid, 1'b0);
        kick(40, 1, 4, 1'b1);
        clk_cycle();
        kick(200, 2, 5, 1'b0);
        beats = 0;
        clk_cycle();
        start = 1'b0;
        wait_done("t4", 4'b1111, 40);
        chk("t4_beats", beats, 4);

        // Reset mid-burst, then a fresh short burst.
        clk_cycle();
        kick(0, 1, 16, 1'b1);
        clk_cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && beats < 3; i++) clk_cycle();
        chk("t5_three_beats", beats, 3);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("t5_rst");
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (2) clk_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_cycle();
            chk("t5_quiet_valid", m_valid, 1'b0);
            chk("t5_quiet_busy", busy, 1'b0);
        end
        kick(20, 2, 2, 1'b1);
        clk_cycle();
        start = 1'b0;
        wait_done("t5", 4'b1111, 40);
        chk("t5_beats", beats, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DLEN, default 32, data word width (matches BRAM DLEN).
REQ-002 SHALL have parameter HLEN, default 9, BRAM address width; depth 2^HLEN.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port base_addr  input  HLEN  first read address, sampled with start.
REQ-007 SHALL have port stride  input  HLEN  address increment per word, sampled with start.
REQ-008 SHALL have port len  input  HLEN+1  word count 0..2^HLEN, sampled with start.
REQ-009 SHALL have port raddr  output  HLEN  registered BRAM read address.
REQ-010 SHALL have port rdata  input  DLEN  BRAM registered read data (valid one cycle after raddr).
REQ-011 SHALL have port m_valid  output  1  stream word valid.
REQ-012 SHALL have port m_ready  input  1  downstream accept; beat = m_valid & m_ready.
REQ-013 SHALL have port m_data  output  DLEN  stream word.
REQ-014 SHALL have port m_last  output  1  high with final word of burst.
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE; busy high in READ and DRAIN.
REQ-018 SHALL, in IDLE on start with len>0, latch base_addr/stride/len and enter READ.
REQ-019 SHALL, on start with len=0, stay IDLE, emit no beat, pulse done the following cycle.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL issue reads in order base, base+stride, base+2*stride, ... modulo 2^HLEN (wrap-around, no error).
REQ-022 SHALL track one-cycle BRAM latency with an in-flight flag; rdata captured into output buffer the cycle after issue.
REQ-023 SHALL issue a read in a cycle only if (buffer occupancy + in-flight − beat this cycle) < 2; never overflow, never drop a word.
REQ-024 SHALL, with m_ready held high, sustain one beat per cycle after the first.
REQ-025 SHALL present first m_valid in the 3rd cycle after the edge sampling start (raddr cycle 1, rdata cycle 2, m_valid cycle 3).
REQ-026 SHALL keep m_data/m_last stable while m_valid & !m_ready.
REQ-027 SHALL enter DRAIN after the len-th read is issued; return to IDLE and pulse done the cycle after the beat with m_last.
REQ-028 SHALL assert m_last only on the len-th beat; len=1 gives one beat with m_last=1.
REQ-029 SHALL accept a new start in the cycle done is high (back-to-back bursts).

Reset
REQ-030 SHALL, on reset_n low, asynchronously force IDLE, raddr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, buffer empty, in-flight cleared.
REQ-031 SHALL discard any in-flight read and buffered words when reset asserts mid-burst; no beat after release until a new start.

Structure
REQ-032 SHALL place FSM state encoding and default DLEN/HLEN constants in shared package bram_rd_pkg.
REQ-033 SHALL use one sub-module bram_rd_fifo2: 2-entry show-ahead buffer with occupancy count.
REQ-034 SHALL contain no storage array beyond the 2-entry buffer; BRAM is external.

Verification
REQ-035 SHALL test base=0, stride=1, len=8, m_ready=1, BRAM[i]=i -> data 0..7 on consecutive cycles, first at cycle 3, m_last on 7, done one cycle after.
REQ-036 SHALL test base=510, stride=3, len=4, HLEN=9 -> addresses 510,1,4,7 (wrap), data in that order.
REQ-037 SHALL test len=8 with m_ready toggling 1,0,0,1 pattern -> all 8 words in order, none lost/duplicated, data stable while stalled.
REQ-038 SHALL test len=0 start -> no m_valid, done pulse next cycle; start while busy -> ignored, beat count unchanged.
REQ-039 SHALL test reset_n low after 3 beats of len=16 -> all outputs zero immediately; new start len=2 afterwards yields exactly 2 correct beats.
